iser_fco_align_ctrl: RTL



---
 rtl/iser_fco_align_ctrl_pkg.sv | 30 +++
 rtl/iser_fco_align_ctrl_if.sv | 48 ++++
 rtl/iser_fco_edge_det.sv | 51 +++++
 rtl/iser_fco_align_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/iser_fco_align_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | iser_pkg: shared types and constants for the FCO frame-alignment slice.     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package iser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } align_state_t;

  localparam int FRAME_NIBS_16B = 4;
  localparam int FRAME_NIBS_12B = 3;

  localparam logic [1:0] FCO_EDGE_POS0 = 2'b11;
  localparam logic [1:0] FCO_EDGE_POS1 = 2'b01;
  localparam logic [1:0] FCO_LOW       = 2'b00;

  // Last nibble index of a frame for the selected sample width.
  function automatic logic [1:0] frame_last(input logic sel_num_bits);
    return sel_num_bits ? 2'(FRAME_NIBS_12B - 1) : 2'(FRAME_NIBS_16B - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iser_fco_align_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | iser_fco_align_ctrl_if: control/status bundle of the FCO alignment block.   |
// | Optional align_err_cnt present with ISER_FCO_ALIGN_ERR_CNT_EN.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface iser_fco_align_ctrl_if
`ifdef ISER_FCO_ALIGN_ERR_CNT_EN
  #(parameter int ERR_W = 16)
`endif
  ;

  logic       enable;
  logic       sel_num_bits;
  logic [1:0] fco_nib;
  logic       fco_strobe;
  logic       fco_position;
  logic       locked;
  logic [1:0] align_state;

`ifdef ISER_FCO_ALIGN_ERR_CNT_EN
  logic [ERR_W-1:0] align_err_cnt;

  modport master (
    output enable, sel_num_bits, fco_nib,
    input  fco_strobe, fco_position, locked, align_state, align_err_cnt
  );

  modport slave (
    input  enable, sel_num_bits, fco_nib,
    output fco_strobe, fco_position, locked, align_state, align_err_cnt
  );
`else
  modport master (
    output enable, sel_num_bits, fco_nib,
    input  fco_strobe, fco_position, locked, align_state
  );

  modport slave (
    input  enable, sel_num_bits, fco_nib,
    output fco_strobe, fco_position, locked, align_state
  );
`endif

endinterface

`default_nettype wire

// File: rtl/iser_fco_edge_det.sv
// +----------------------------------------------------------------------------+
// | iser_fco_edge_det: two-stage FCO sample pipeline and rising-edge decode.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iser_fco_edge_det
  import iser_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] fco_nib,
  output logic       fco_edge,
  output logic       fco_pos
);

  logic [1:0] cur_q, cur_d;
  logic [1:0] prev_q, prev_d;

  always_comb begin
    cur_d  = fco_nib;
    prev_d = cur_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= 2'b00;
      prev_q <= 2'b00;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
    end
  end

  // A full low pair must precede the rise; bit[1] high means the edge sits on the boundary.
  always_comb begin
    fco_edge = 1'b0;
    fco_pos  = 1'b0;
    if (prev_q == FCO_LOW) begin
      if (cur_q == FCO_EDGE_POS0) begin
        fco_edge = 1'b1;
      end else if (cur_q == FCO_EDGE_POS1) begin
        fco_edge = 1'b1;
        fco_pos  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/iser_fco_align_ctrl.sv
// +----------------------------------------------------------------------------+
// | iser_fco_align_ctrl: FCO frame-boundary search, lock qualification and      |
// | strobe flywheel. Optional error counter: ISER_FCO_ALIGN_ERR_CNT_EN.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iser_fco_align_ctrl
  import iser_pkg::*;
#(
  parameter int LOCK_CNT = 8,
  parameter int LOSS_CNT = 4
`ifdef ISER_FCO_ALIGN_ERR_CNT_EN
  ,
  parameter int ERR_W    = 16
`endif
) (
  input  logic                  data_clk,
  input  logic                  rst_n,
  iser_fco_align_ctrl_if.slave  bus
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(LOSS_CNT + 1);

  logic fco_edge;
  logic fco_pos;

  iser_fco_edge_det u_edge_det (
    .clk      (data_clk),
    .rst_n    (rst_n),
    .fco_nib  (bus.fco_nib),
    .fco_edge (fco_edge),
    .fco_pos  (fco_pos)
  );

  align_state_t         state_q, state_d;
  logic [1:0]           nib_cnt_q, nib_cnt_d;
  logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
  logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
  logic                 fco_position_q, fco_position_d;
  logic                 fco_strobe_q, fco_strobe_d;
  logic                 locked_q, locked_d;
  logic                 sel_q, sel_d;

  logic       nib_zero;
  logic [1:0] nib_next;
  logic       frame_match;
  logic       frame_miss;
  logic       sel_change;

  assign nib_zero    = (nib_cnt_q == 2'd0);
  assign nib_next    = (nib_cnt_q >= frame_last(bus.sel_num_bits)) ? 2'd0 : nib_cnt_q + 2'd1;
  assign frame_match = fco_edge && (fco_pos == fco_position_q);
  // An edge away from the expected slot is as bad as a missing one.
  assign frame_miss  = nib_zero ? !frame_match : fco_edge;
  assign sel_change  = (bus.sel_num_bits != sel_q);

  always_comb begin
    state_d        = state_q;
    nib_cnt_d      = nib_cnt_q;
    match_cnt_d    = match_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    fco_position_d = fco_position_q;
    fco_strobe_d   = 1'b0;
    sel_d          = bus.sel_num_bits;

    if (!bus.enable) begin
      state_d        = IDLE;
      nib_cnt_d      = 2'd0;
      match_cnt_d    = '0;
      miss_cnt_d     = '0;
      fco_position_d = 1'b0;
    end else if (sel_change) begin
      state_d     = SEARCH;
      nib_cnt_d   = 2'd0;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = SEARCH;
          nib_cnt_d   = 2'd0;
          match_cnt_d = '0;
          miss_cnt_d  = '0;
        end
        SEARCH: begin
          if (fco_edge) begin
            state_d        = VERIFY;
            fco_position_d = fco_pos;
            nib_cnt_d      = 2'd1;
            match_cnt_d    = '0;
            miss_cnt_d     = '0;
          end
        end
        VERIFY: begin
          nib_cnt_d = nib_next;
          if (frame_miss) begin
            state_d     = SEARCH;
            nib_cnt_d   = 2'd0;
            match_cnt_d = '0;
          end else if (nib_zero) begin
            if (match_cnt_q == MATCH_W'(LOCK_CNT - 1)) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end else if (match_cnt_q != {MATCH_W{1'b1}}) begin
              match_cnt_d = match_cnt_q + MATCH_W'(1);
            end
          end
        end
        LOCKED: begin
          nib_cnt_d    = nib_next;
          fco_strobe_d = nib_zero;
          if (frame_miss) begin
            if (miss_cnt_q >= MISS_W'(LOSS_CNT - 1)) begin
              state_d      = SEARCH;
              fco_strobe_d = 1'b0;
              nib_cnt_d    = 2'd0;
              miss_cnt_d   = '0;
              match_cnt_d  = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end else if (nib_zero) begin
            miss_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      nib_cnt_q      <= 2'd0;
      match_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      fco_position_q <= 1'b0;
      fco_strobe_q   <= 1'b0;
      locked_q       <= 1'b0;
      sel_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      nib_cnt_q      <= nib_cnt_d;
      match_cnt_q    <= match_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      fco_position_q <= fco_position_d;
      fco_strobe_q   <= fco_strobe_d;
      locked_q       <= locked_d;
      sel_q          <= sel_d;
    end
  end

  assign bus.fco_strobe   = fco_strobe_q;
  assign bus.fco_position = fco_position_q;
  assign bus.locked       = locked_q;
  assign bus.align_state  = state_q;

`ifdef ISER_FCO_ALIGN_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [1:0]       err_inc;
  logic [ERR_W:0]   err_sum;

  // Losing lock on a miss costs two: the miss itself and the drop to SEARCH.
  always_comb begin
    err_inc = 2'd0;
    if (bus.enable && (state_q == LOCKED)) begin
      err_inc = {1'b0, (frame_miss && !sel_change)} + {1'b0, (state_d == SEARCH)};
    end
    err_sum   = {1'b0, err_cnt_q} + (ERR_W + 1)'(err_inc);
    err_cnt_d = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    if (!bus.enable) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge data_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.align_err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire
